// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU (port 0) and a debug/DMA loader (port 1).
// Each grant becomes a one-cycle MemWrite pulse, or a MemRead pulse followed by a forced low cycle.
module dmem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_Data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD      = 2'd2;
  localparam logic [1:0] RD_DONE = 2'd3;

  logic [1:0]        r_state;
  logic              r_winner;
  logic              r_last;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              r_mem_write;
  logic              r_mem_read;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_any_req;
  logic              w_tie_to1;
  logic              w_pick1;
  logic              w_accept;
  logic              w_rd_done;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // r_last = 1 means port 1 held the most recent grant; round-robin hands a tie to the other port
  assign w_any_req   = req0 | req1;
  assign w_tie_to1   = (RR != 0) && !r_last;
  assign w_pick1     = req1 && (!req0 || w_tie_to1);
  assign w_accept    = (r_state == IDLE) && w_any_req;
  assign w_rd_done   = (r_state == RD);
  assign w_sel_we    = w_pick1 ? we1    : we0;
  assign w_sel_addr  = w_pick1 ? addr1  : addr0;
  assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_winner    <= 1'b0;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_winner <= w_pick1;
            r_last   <= w_pick1;
            r_gnt0   <= !w_pick1;
            r_gnt1   <= w_pick1;
            if (w_sel_we) begin
              r_mem_write <= 1'b1;
              r_state     <= WR;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= RD;
            end
          end
        end
        WR:      r_state <= IDLE;
        RD:      r_state <= RD_DONE;
        // RD_DONE keeps MemRead low for one full cycle before the next acceptance
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_rd_done && !r_winner;
      r_rvalid1 <= w_rd_done && r_winner;
      if (w_rd_done && !r_winner) begin
        r_rdata0 <= Read_Data;
      end
      if (w_rd_done && r_winner) begin
        r_rdata1 <= Read_Data;
      end
    end
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign rvalid0    = r_rvalid0;
  assign rvalid1    = r_rvalid1;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
  assign busy       = (r_state != IDLE);
  assign MemWrite   = r_mem_write;
  assign MemRead    = r_mem_read;
  assign Address    = r_addr;
  assign Write_data = r_wdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-cycle CPU's data memory. It shares the one memory port between port 0 (CPU load/store stage) and port 1 (debug/DMA loader). It converts each accepted request into a correctly shaped memory access:

- a one-cycle MemWrite pulse, because the memory commits on the falling clock edge;
- a MemRead pulse followed by a mandatory low cycle, because the memory captures reads on the rising edge of MemRead.

Read data is returned to the requesting port only.

## Interface
Parameters:
- ADDR_W, 13, word address width (8192-word memory)
- DATA_W, 32, data width
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 always wins)

Ports. Clock is `clock` and reset is `reset`: one clock; reset is asynchronous and active-high.
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  access request, held until gnt of the same port
- we0, we1  in  1  1 = write, 0 = read; valid while req is high
- addr0, addr1  in  ADDR_W  word address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and operands latched
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata of that port is valid
- rdata0, rdata1  out  DATA_W  read result, held until the next read on that port
- busy  out  1  high in any state other than IDLE
- MemWrite, MemRead  out  1  memory strobes, driven from registers
- Address  out  ADDR_W  registered memory address
- Write_data  out  DATA_W  registered memory write data
- Read_Data  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, WR, RD, RD_DONE.
- IDLE, no req: stay in IDLE.
- IDLE, req present:
  - select a winner.
  - latch Address, Write_data and the winner id.
  - pulse gnt of the winner.
  - go to WR with MemWrite=1 if we is set, otherwise go to RD with MemRead=1.
- WR → IDLE, with MemWrite=0.
- RD → RD_DONE:
  - capture Read_Data into rdata of the winner.
  - pulse rvalid of the winner.
  - MemRead=0.
- RD_DONE → IDLE. MemRead stays 0, which guarantees at least one low cycle between read pulses.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, RR=1: the port not granted last wins.
  - Both requesting, RR=0: port 0 wins.
  - The last-grant pointer updates on every grant. Its reset value is "port 1 last", so port 0 wins the first tie.
- Requester inputs are sampled only in IDLE. A req still high in IDLE after its gnt counts as a new request.
- rdata of the port that is not the winner never changes.
- Reset values:
  - state = IDLE.
  - MemWrite, MemRead, all gnt and rvalid = 0.
  - Address, Write_data, rdata0, rdata1 = 0.
  - Last-grant pointer = port 1.
- Reset mid-operation:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - An in-flight read produces no rvalid.
  - A write whose MemWrite is cleared before the falling edge is not committed.

## Timing
- Request sampled at edge k in IDLE:
  - gnt is high during cycle k→k+1.
  - MemWrite or MemRead is high during cycle k→k+1.
- Write:
  - Memory commits at the falling edge in cycle k→k+1.
  - IDLE at edge k+1.
  - Next acceptance at edge k+2 at the earliest, giving 1 write per 2 cycles.
- Read:
  - Read_Data is valid after edge k and is sampled at edge k+1.
  - rvalid is high during cycle k+1→k+2.
  - IDLE at k+2. Next acceptance at edge k+3, giving 1 read per 3 cycles.
- The port that loses waits. A requester holding req sees gnt no later than 2 transactions later under RR=1.

## Test plan
- Reset then single write:
  - Stimulus: req0=1, we0=1, addr0=5, wdata0=0x0000_00AB.
  - Required response: gnt0 for 1 cycle; MemWrite for 1 cycle with Address=5 and Write_data=0xAB; busy high for 1 cycle.
- Read back:
  - Stimulus: req1=1, we1=0, addr1=5.
  - Required response: MemRead high for 1 cycle then low; rvalid1 2 cycles after acceptance with rdata1=0xAB; rdata0 unchanged.
- Both ports request reads continuously, RR=1:
  - Required response: grants alternate 0,1,0,1; MemRead low for at least 1 cycle between every pulse; each rvalid goes to the matching port.
- Same as the previous scenario with RR=0:
  - Required response: port 0 is granted every time and port 1 is never granted while req0 is held.
- Back-to-back writes to addresses 0..3 with data 10..13:
  - Required response: accepted every 2 cycles; memory contains 10..13.
- Reset mid-access:
  - Stimulus: assert reset in the RD cycle.
  - Required response: MemRead drops immediately; no rvalid; FSM in IDLE; the next request is served normally.
